// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Purpose  : Aggregates NUM_IRQS asynchronous interrupt sources into one
//            active-high irq_out. IE/IP/RAW/CFG live on the shared 5-bit CSR
//            bus, and a holdoff gap follows every acknowledge.
// Option   : IRQ_CTRL_LEVEL_EN -- adds per-source level mode via CFG (+3)
// Revision : 1.0  initial release
// ============================================================================
module irq_ctrl #(
    parameter logic [4:0] BASE_ADDR      = 5'h08,
    parameter int         NUM_IRQS       = 8,
    parameter int         HOLDOFF_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          csr_a,
    input  logic [7:0]          csr_di,
    input  logic                csr_we,
    output logic [7:0]          csr_do,
    input  logic [NUM_IRQS-1:0] irq_in,
    output logic                irq_out
);

    localparam logic [4:0] c_addr_ie  = BASE_ADDR;
    localparam logic [4:0] c_addr_ip  = BASE_ADDR + 5'd1;
    localparam logic [4:0] c_addr_raw = BASE_ADDR + 5'd2;
    localparam logic [4:0] c_addr_cfg = BASE_ADDR + 5'd3;

    localparam logic [7:0] c_hold_load = 8'(HOLDOFF_CYCLES - 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_assert  = 2'd1;
    localparam logic [1:0] c_st_holdoff = 2'd2;

    logic [NUM_IRQS-1:0] sync1_q, sync1_d;
    logic [NUM_IRQS-1:0] sync2_q, sync2_d;
    logic [NUM_IRQS-1:0] prev_q,  prev_d;
    logic [NUM_IRQS-1:0] ie_q,    ie_d;
    logic [NUM_IRQS-1:0] ip_q,    ip_d;
    logic [1:0]          state_q, state_d;
    logic [7:0]          cnt_q,   cnt_d;

    logic [NUM_IRQS-1:0] w_edge;
    logic [NUM_IRQS-1:0] w_set;
    logic [NUM_IRQS-1:0] w_clr;
    logic                w_wr_ie;
    logic                w_wr_ip;
    logic                w_active;
    logic [7:0]          w_ie_rd;
    logic [7:0]          w_ip_rd;
    logic [7:0]          w_raw_rd;
    logic [7:0]          w_cfg_rd;

`ifdef IRQ_CTRL_LEVEL_EN
    logic [NUM_IRQS-1:0] cfg_q, cfg_d;
    logic                w_wr_cfg;
`endif

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            ie_q    <= '0;
            ip_q    <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            ie_q    <= ie_d;
            ip_q    <= ip_d;
        end
    end

`ifdef IRQ_CTRL_LEVEL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Synchroniser, edge detect, pending and enable update
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d = irq_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        w_edge  = sync2_q & ~prev_q;
        w_wr_ie = csr_we && (csr_a == c_addr_ie);
        w_wr_ip = csr_we && (csr_a == c_addr_ip);

`ifdef IRQ_CTRL_LEVEL_EN
        w_wr_cfg = csr_we && (csr_a == c_addr_cfg);
        cfg_d    = cfg_q;
        if (w_wr_cfg) begin
            cfg_d = csr_di[NUM_IRQS-1:0];
        end
        // Level sources re-set every cycle the input is high.
        w_set = (w_edge & ~cfg_q) | (sync2_q & cfg_q);
`else
        w_set = w_edge;
`endif

        ie_d = ie_q;
        if (w_wr_ie) begin
            ie_d = csr_di[NUM_IRQS-1:0];
        end

        w_clr = '0;
        if (w_wr_ip) begin
            w_clr = csr_di[NUM_IRQS-1:0];
        end
        // OR-ing the set term last lets a same-cycle set beat the W1C.
        ip_d = (ip_q & ~w_clr) | w_set;

        w_active = |(ip_q & ie_q);
    end

    // ------------------------------------------------------------------
    // CSR read mux (zero when not addressed, for bus OR-combining)
    // ------------------------------------------------------------------
    always_comb begin
        w_ie_rd  = '0;
        w_ip_rd  = '0;
        w_raw_rd = '0;
        w_cfg_rd = '0;
        w_ie_rd[NUM_IRQS-1:0]  = ie_q;
        w_ip_rd[NUM_IRQS-1:0]  = ip_q;
        w_raw_rd[NUM_IRQS-1:0] = sync2_q;
`ifdef IRQ_CTRL_LEVEL_EN
        w_cfg_rd[NUM_IRQS-1:0] = cfg_q;
`endif

        case (csr_a)
            c_addr_ie:  csr_do = w_ie_rd;
            c_addr_ip:  csr_do = w_ip_rd;
            c_addr_raw: csr_do = w_raw_rd;
            c_addr_cfg: csr_do = w_cfg_rd;
            default:    csr_do = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Output FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_st_idle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: any IP write acknowledges, even with zero data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_st_idle: begin
                if (w_active) begin
                    state_d = c_st_assert;
                end
            end
            c_st_assert: begin
                if (w_wr_ip) begin
                    state_d = c_st_holdoff;
                    cnt_d   = c_hold_load;
                end else if (!w_active) begin
                    state_d = c_st_idle;
                end
            end
            c_st_holdoff: begin
                if (cnt_q == 8'd0) begin
                    state_d = c_st_idle;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // Output decode
    always_comb begin
        irq_out = (state_q == c_st_assert);
    end

endmodule
`default_nettype wire
